// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: shares one 8N1 UART TX line between NUM_CH count-word requesters.
// A round-robin arbiter grants one requester per frame. The granted word is sent as
//   SYNC_BYTE, channel index, DATA_W/8 payload bytes (least-significant byte first)
// with each bit lasting one baud_tick interval.
// Optional feature macro: UART_TX_CHECKSUM_EN appends an XOR checksum byte (channel index
// byte XOR all payload bytes) after the payload.
// NUM_CH must be 2..8 and DATA_W a multiple of 8.
module uart_tx_scheduler #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DATA_W    = 32,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     baud_tick,
  input  logic [NUM_CH-1:0]        req_valid,
  input  logic [NUM_CH*DATA_W-1:0] req_data,
  output logic [NUM_CH-1:0]        req_ready,
  output logic                     tx,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned NumPay   = DATA_W / 8;
`ifdef UART_TX_CHECKSUM_EN
  localparam int unsigned NumBytes = NumPay + 3;
`else
  localparam int unsigned NumBytes = NumPay + 2;
`endif
  localparam int unsigned ChW      = $clog2(NUM_CH);
  localparam int unsigned ByteW    = $clog2(NumPay + 3);
  localparam logic [ByteW-1:0] LastByte = ByteW'(NumBytes - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWaitTick,
    StStart,
    StData,
    StStop
  } state_e;

  state_e              state_q, state_d;
  logic [ChW-1:0]      rr_q, rr_d;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [ByteW-1:0]    byte_cnt_q, byte_cnt_d;
  logic                tx_q, tx_d;

  logic                grant_found;
  logic [ChW-1:0]      grant_idx;
  logic [7:0]          ch_byte;
  logic [7:0]          cur_byte;
  logic [2:0]          bit_nxt;

  // Channel index byte is the captured index zero-extended to 8 bits.
  assign ch_byte = 8'(ch_q);
  assign bit_nxt = bit_cnt_q + 3'd1;
  assign tx      = tx_q;

  // Round-robin search: first asserted request at or above rr_q, wrapping to 0.
  always_comb begin
    int unsigned idx;
    logic [ChW-1:0] idx_c;
    idx         = 0;
    idx_c       = '0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx = 32'(rr_q) + k;
      if (idx >= NUM_CH) begin
        idx = idx - NUM_CH;
      end
      idx_c = idx[ChW-1:0];
      if (!grant_found && req_valid[idx_c]) begin
        grant_found = 1'b1;
        grant_idx   = idx_c;
      end
    end
  end

`ifdef UART_TX_CHECKSUM_EN
  logic [7:0] csum;

  // Checksum covers the channel index byte and every payload byte, not the sync byte.
  always_comb begin
    csum = ch_byte;
    for (int unsigned p = 0; p < NumPay; p++) begin
      csum = csum ^ data_q[p*8 +: 8];
    end
  end
`endif

  // Select the frame byte currently being serialised from the byte counter.
  always_comb begin
    cur_byte = SYNC_BYTE;
    if (byte_cnt_q == ByteW'(1)) begin
      cur_byte = ch_byte;
    end
    for (int unsigned p = 0; p < NumPay; p++) begin
      if (byte_cnt_q == ByteW'(p + 2)) begin
        cur_byte = data_q[p*8 +: 8];
      end
    end
`ifdef UART_TX_CHECKSUM_EN
    if (byte_cnt_q == LastByte) begin
      cur_byte = csum;
    end
`endif
  end

  // Next-state and output logic; tx only moves on cycles carrying baud_tick.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    ch_d       = ch_q;
    data_d     = data_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    tx_d       = tx_q;
    req_ready  = '0;
    frame_done = 1'b0;
    busy       = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        // baud_tick is deliberately ignored here so the grant cycle never starts a bit.
        if (grant_found && !rst) begin
          req_ready[grant_idx] = 1'b1;
          ch_d                 = grant_idx;
          data_d               = req_data[grant_idx*DATA_W +: DATA_W];
          rr_d                 = (32'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + ChW'(1);
          busy                 = 1'b1;
          bit_cnt_d            = '0;
          byte_cnt_d           = '0;
          tx_d                 = 1'b1;
          state_d              = StWaitTick;
        end
      end
      StWaitTick: begin
        // First tick after the grant opens a full-length start bit.
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_tick) begin
          tx_d      = cur_byte[0];
          bit_cnt_d = '0;
          state_d   = StData;
        end
      end
      StData: begin
        if (baud_tick) begin
          if (bit_cnt_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_cnt_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end
      end
      StStop: begin
        if (baud_tick) begin
          if (byte_cnt_q == LastByte) begin
            frame_done = 1'b1;
            state_d    = StIdle;
          end else begin
            // Next start bit follows the stop bit directly, no idle gap.
            byte_cnt_d = byte_cnt_q + ByteW'(1);
            tx_d       = 1'b0;
            state_d    = StStart;
          end
        end
      end
      default: begin
        state_d = StIdle;
        tx_d    = 1'b1;
      end
    endcase

    // An abandoned frame must not report completion.
    if (rst) begin
      frame_done = 1'b0;
    end
  end

  // State register with synchronous reset; reset abandons any frame and rewinds rr.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_q       <= '0;
      ch_q       <= '0;
      data_q     <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      ch_q       <= ch_d;
      data_q     <= data_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      tx_q       <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Testbench for uart_tx_scheduler: a frame-level reference model predicts grants, frame
// bytes, frame_done timing and busy; a separate monitor decodes tx and compares.
module tb_uart_tx_scheduler;

  localparam int unsigned NumCh = 4;
  localparam int unsigned DataW = 32;
  localparam logic [7:0]  Sync  = 8'hA5;
  localparam int unsigned NPay  = DataW / 8;
`ifdef UART_TX_CHECKSUM_EN
  localparam int unsigned NBytes = NPay + 3;
`else
  localparam int unsigned NBytes = NPay + 2;
`endif
  // Ticks counted after the grant cycle up to and including the frame_done tick.
  localparam int FrameTicks = 10 * NBytes + 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    baud_tick;
  logic [NumCh-1:0]        req_valid;
  logic [NumCh*DataW-1:0]  req_data;
  logic [NumCh-1:0]        req_ready;
  logic                    tx;
  logic                    busy;
  logic                    frame_done;

  uart_tx_scheduler #(
    .NUM_CH   (NumCh),
    .DATA_W   (DataW),
    .SYNC_BYTE(Sync)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Tick generator controls.
  bit tick_en     = 1'b1;
  bit tick_rand   = 1'b0;
  int tick_period = 16;

  // Reference model state and scoreboard queues.
  int          m_rr      = 0;
  bit          m_busy    = 1'b0;
  int          m_ticks   = 0;
  int          m_grants  = 0;
  int          m_dones   = 0;
  bit          m_gflag   = 1'b0;
  int          m_gch     = 0;
  bit          exp_busy  = 1'b0;
  int          exp_gch_q[$];
  int          exp_gcyc_q[$];
  int          exp_done_q[$];
  logic [7:0]  exp_byte_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bad(input string name, input string why);
    checks++;
    failures++;
    $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin : cycle_counter
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin : tick_gen
    int cnt;
    cnt       = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!tick_en) begin
        baud_tick = 1'b0;
      end else if (tick_rand) begin
        baud_tick = ($urandom_range(0, 2) == 0);
      end else begin
        cnt++;
        if (cnt >= tick_period) begin
          cnt       = 0;
          baud_tick = 1'b1;
        end else begin
          baud_tick = 1'b0;
        end
      end
    end
  end

  // Reference model: evaluated once per cycle on the inputs the next edge will see.
  initial begin : model
    int          g;
    int          c;
    logic [DataW-1:0] w;
    logic [7:0]  cs;
    forever begin
      @(negedge clk);
      m_gflag = 1'b0;
      if (rst) begin
        m_rr   = 0;
        m_busy = 1'b0;
        exp_busy = 1'b0;
        exp_byte_q.delete();
      end else if (!m_busy) begin
        exp_busy = 1'b0;
        if (req_valid != '0) begin
          g = -1;
          for (int k = 0; k < NumCh; k++) begin
            c = (m_rr + k) % NumCh;
            if (g < 0 && req_valid[c]) g = c;
          end
          w  = req_data[g*DataW +: DataW];
          cs = 8'(g);
          exp_byte_q.push_back(Sync);
          exp_byte_q.push_back(8'(g));
          for (int p = 0; p < NPay; p++) begin
            exp_byte_q.push_back(w[p*8 +: 8]);
            cs = cs ^ w[p*8 +: 8];
          end
`ifdef UART_TX_CHECKSUM_EN
          exp_byte_q.push_back(cs);
`endif
          exp_gch_q.push_back(g);
          exp_gcyc_q.push_back(cyc);
          m_rr     = (g + 1) % NumCh;
          m_busy   = 1'b1;
          m_ticks  = 0;
          exp_busy = 1'b1;
          m_grants++;
          m_gflag  = 1'b1;
          m_gch    = g;
        end
      end else begin
        exp_busy = 1'b1;
        if (baud_tick) begin
          m_ticks++;
          if (m_ticks == FrameTicks) begin
            exp_done_q.push_back(cyc);
            m_busy = 1'b0;
            m_dones++;
          end
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the scoreboard and decodes the tx line.
  initial begin : monitor
    logic       last_tick;
    logic       last_rst;
    logic       last_tx;
    int         dst;
    int         nb;
    logic [7:0] sh;
    logic [7:0] eb;
    int         gch;
    int         gcy;
    int         dcy;
    dst = 0;
    nb  = 0;
    sh  = '0;
    @(negedge clk);
    #1;
    last_tick = baud_tick;
    last_rst  = rst;
    last_tx   = tx;
    forever begin
      @(negedge clk);
      #1;
      if (req_ready != '0) begin
        if (exp_gch_q.size() == 0) begin
          bad("grant", "unexpected req_ready");
        end else begin
          gch = exp_gch_q.pop_front();
          gcy = exp_gcyc_q.pop_front();
          chk("grant_onehot", 64'(req_ready), 64'(1) << gch);
          chk("grant_cycle", 64'(cyc), 64'(gcy));
        end
      end
      if (frame_done === 1'b1) begin
        if (exp_done_q.size() == 0) begin
          bad("frame_done", "unexpected frame_done");
        end else begin
          dcy = exp_done_q.pop_front();
          chk("frame_done_cycle", 64'(cyc), 64'(dcy));
        end
      end
      if (!rst) chk("busy", 64'(busy), 64'(exp_busy));
      if (rst) begin
        dst = 0;
      end else if (last_rst) begin
        chk("tx_after_rst", 64'(tx), 64'(1));
        dst = 0;
      end else if (last_tick) begin
        case (dst)
          0: begin
            if (tx === 1'b0) begin
              dst = 1;
              nb  = 0;
            end
          end
          1: begin
            sh[nb] = tx;
            nb++;
            if (nb == 8) dst = 2;
          end
          default: begin
            chk("stop_bit", 64'(tx), 64'(1));
            if (exp_byte_q.size() == 0) begin
              bad("byte", "unexpected byte on tx");
            end else begin
              eb = exp_byte_q.pop_front();
              chk("byte", 64'(sh), 64'(eb));
            end
            dst = 0;
          end
        endcase
      end else begin
        chk("tx_stable", 64'(tx), 64'(last_tx));
      end
      last_tick = baud_tick;
      last_rst  = rst;
      last_tx   = tx;
    end
  end

  task automatic wait_grants(input int target, input int budget);
    int n;
    n = 0;
    while (m_grants < target && n < budget) begin
      step(1);
      n++;
    end
    if (m_grants < target) bad("timeout_grant", "grant not reached");
  endtask

  task automatic wait_dones(input int target, input int budget);
    int n;
    n = 0;
    while (m_dones < target && n < budget) begin
      step(1);
      n++;
    end
    if (m_dones < target) bad("timeout_done", "frame end not reached");
  endtask

  task automatic wait_ticks(input int target, input int budget);
    int n;
    n = 0;
    while (!(m_busy && m_ticks >= target) && n < budget) begin
      step(1);
      n++;
    end
    if (!(m_busy && m_ticks >= target)) bad("timeout_tick", "tick count not reached");
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step(2);
    rst = 1'b0;
  endtask

  task automatic rand_data();
    for (int c = 0; c < NumCh; c++) req_data[c*DataW +: DataW] = $urandom();
  endtask

  initial begin : stimulus
    int d;
    int g;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    step(3);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("reset_tx", 64'(tx), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_ready", 64'(req_ready), 64'(0));
    chk("reset_done", 64'(frame_done), 64'(0));
    step(1);

    // Channel 2 alone, tick every 16 clocks.
    tick_period = 16;
    rand_data();
    req_data[2*DataW +: DataW] = 32'h12345678;
    req_valid = 4'b0100;
    g = m_grants;
    wait_grants(g + 1, 50);
    req_valid = '0;
    rand_data();
    wait_dones(m_dones + 1, 2000);
    step(20);

    // All four held from reset: 0,1,2,3,0 back to back.
    do_reset();
    tick_period = 4;
    rand_data();
    req_valid = 4'b1111;
    d = m_dones;
    wait_dones(d + 5, 3000);
    req_valid = '0;
    step(10);

    // ch0 and ch3 held: alternation.
    do_reset();
    req_valid = 4'b1001;
    d = m_dones;
    wait_dones(d + 4, 3000);
    req_valid = '0;
    step(10);

    // Tick stall for 500 clocks in the middle of a data byte.
    tick_period = 8;
    rand_data();
    req_valid = 4'b0010;
    g = m_grants;
    wait_grants(g + 1, 50);
    req_valid = '0;
    wait_ticks(25, 1000);
    tick_en = 1'b0;
    step(500);
    tick_en = 1'b1;
    wait_dones(m_dones + 1, 2000);
    step(10);

    // Reset during the third payload byte, then rr must restart at 0.
    rand_data();
    req_valid = 4'b0100;
    g = m_grants;
    wait_grants(g + 1, 50);
    req_valid = '0;
    wait_ticks(45, 1000);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    #2;
    chk("midrst_tx", 64'(tx), 64'(1));
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_done", 64'(frame_done), 64'(0));
    step(1);
    req_valid = 4'b1010;
    g = m_grants;
    wait_grants(g + 1, 50);
    req_valid = '0;
    wait_dones(m_dones + 1, 2000);
    step(10);

    // Randomised traffic: requests come and go, data churns, ticks irregular.
    tick_rand = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      step(1);
      rand_data();
      if (m_gflag && $urandom_range(0, 3) != 0) req_valid[m_gch] = 1'b0;
      for (int c = 0; c < NumCh; c++) begin
        if (!req_valid[c] && $urandom_range(0, 15) == 0) req_valid[c] = 1'b1;
        else if (req_valid[c] && $urandom_range(0, 63) == 0) req_valid[c] = 1'b0;
      end
    end
    req_valid   = '0;
    tick_rand   = 1'b0;
    tick_period = 2;

    // Drain: wait for the model to go idle and the DUT to deliver every expected byte.
    d = 0;
    while ((m_busy || exp_byte_q.size() != 0) && d < 3000) begin
      step(1);
      d++;
    end
    if (m_busy || exp_byte_q.size() != 0) bad("timeout_drain", "frames did not drain");
    step(10);
    chk("bytes_left", 64'(exp_byte_q.size()), 64'(0));
    chk("grants_left", 64'(exp_gch_q.size()), 64'(0));
    chk("dones_left", 64'(exp_done_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
